// File: rtl/window_mapper.sv
// Programmable NUM_WIN-window SNES address mapper: shadow/active window tables, atomic bus-idle commit,
// 2-stage decode pipeline. Optional per-window saturating hit counters are enabled by MAPPER_HITCNT_EN.
module window_mapper #(
    parameter int  NUM_WIN = 8,
    parameter int  ADDR_W  = 24,
    localparam int IDX_W   = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] SNES_ADDR,
    input  logic              snes_access,
    input  logic              cfg_we,
    input  logic              cfg_re,
    input  logic [IDX_W+2:0]  cfg_addr,
    input  logic [ADDR_W-1:0] cfg_wdata,
    output logic [ADDR_W-1:0] cfg_rdata,
    input  logic              cfg_commit,
    output logic              cfg_pending,
    output logic              cfg_commit_ack,
    output logic [ADDR_W-1:0] ROM_ADDR,
    output logic              ROM_HIT,
    output logic              IS_SAVERAM,
    output logic              IS_WRITABLE,
    output logic [IDX_W-1:0]  hit_idx
);

    typedef struct packed {
        logic [ADDR_W-1:0] match_val;
        logic [ADDR_W-1:0] match_mask;
        logic [ADDR_W-1:0] xlat_mask;
        logic [ADDR_W-1:0] xlat_base;
        logic [2:0]        flags;
    } win_t;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    localparam logic [2:0] F_MATCH_VAL  = 3'd0;
    localparam logic [2:0] F_MATCH_MASK = 3'd1;
    localparam logic [2:0] F_XLAT_MASK  = 3'd2;
    localparam logic [2:0] F_XLAT_BASE  = 3'd3;
    localparam logic [2:0] F_FLAGS      = 3'd4;
    localparam logic [2:0] F_HITCNT     = 3'd5;

    localparam int FL_EN  = 0;
    localparam int FL_WR  = 1;
    localparam int FL_SAV = 2;

    win_t              shadow_q [NUM_WIN];
    win_t              shadow_d [NUM_WIN];
    win_t              active_q [NUM_WIN];
    win_t              active_d [NUM_WIN];

    state_t            state_q;
    logic              ack_q;
    logic              commit_fire;

    logic [IDX_W-1:0]  cfg_idx;
    logic [2:0]        cfg_field;
    logic              cfg_idx_ok;

    logic [ADDR_W-1:0] rdata_q;
    logic [ADDR_W-1:0] rdata_d;
    logic [ADDR_W-1:0] rdata_sel;

    logic [ADDR_W-1:0] addr1_q;
    logic [ADDR_W-1:0] addr1_d;
    logic [NUM_WIN-1:0] match1_q;
    logic [NUM_WIN-1:0] match1_d;

    logic              win_hit;
    logic [IDX_W-1:0]  win_idx;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [ADDR_W-1:0] rom_addr_d;
    logic              rom_hit_q;
    logic              rom_hit_d;
    logic              saveram_q;
    logic              saveram_d;
    logic              writable_q;
    logic              writable_d;
    logic [IDX_W-1:0]  hit_idx_q;
    logic [IDX_W-1:0]  hit_idx_d;

    assign cfg_idx    = cfg_addr[IDX_W+2:3];
    assign cfg_field  = cfg_addr[2:0];
    assign cfg_idx_ok = (32'(cfg_idx) < 32'(NUM_WIN));

    // The copy happens only on an idle bus cycle, so no access ever sees a half-swapped table.
    assign commit_fire = (state_q == PEND) && !snes_access;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: if (cfg_commit) state_q <= PEND;
                PEND: begin
                    if (!snes_access) begin
                        state_q <= IDLE;
                        ack_q   <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no branch can leave it unassigned and infer a latch.
        shadow_d = shadow_q;
        if (cfg_we && cfg_idx_ok) begin
            case (cfg_field)
                F_MATCH_VAL:  shadow_d[cfg_idx].match_val  = cfg_wdata;
                F_MATCH_MASK: shadow_d[cfg_idx].match_mask = cfg_wdata;
                F_XLAT_MASK:  shadow_d[cfg_idx].xlat_mask  = cfg_wdata;
                F_XLAT_BASE:  shadow_d[cfg_idx].xlat_base  = cfg_wdata;
                F_FLAGS:      shadow_d[cfg_idx].flags      = cfg_wdata[2:0];
                default:      ;
            endcase
        end
    end

    // Copy takes the shadow as it stood before this cycle's write, so a same-cycle cfg_we misses the commit.
    always_comb begin
        active_d = active_q;
        if (commit_fire) active_d = shadow_q;
    end

`ifdef MAPPER_HITCNT_EN
    logic [15:0] hitcnt_q [NUM_WIN];
    logic [15:0] hitcnt_d [NUM_WIN];
    logic        acc1_q;
    logic        acc2_q;
    logic        acc3_q;
    logic        acc_rise2;

    // acc2/acc3 line the access rising edge up with the stage-2 result of the address sampled on that edge.
    assign acc_rise2 = acc2_q && !acc3_q;

    always_comb begin
        hitcnt_d = hitcnt_q;
        for (int i = 0; i < NUM_WIN; i++) begin
            if (cfg_we && cfg_idx_ok && cfg_field == F_HITCNT && cfg_idx == IDX_W'(i)) begin
                hitcnt_d[i] = '0;
            end else if (acc_rise2 && rom_hit_q && hit_idx_q == IDX_W'(i)
                         && hitcnt_q[i] != 16'hFFFF) begin
                hitcnt_d[i] = hitcnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_WIN; i++) hitcnt_q[i] <= '0;
            acc1_q <= 1'b0;
            acc2_q <= 1'b0;
            acc3_q <= 1'b0;
        end else begin
            hitcnt_q <= hitcnt_d;
            acc1_q   <= snes_access;
            acc2_q   <= acc1_q;
            acc3_q   <= acc2_q;
        end
    end
`endif

    always_comb begin
        rdata_sel = '0;
        if (cfg_idx_ok) begin
            case (cfg_field)
                F_MATCH_VAL:  rdata_sel = shadow_q[cfg_idx].match_val;
                F_MATCH_MASK: rdata_sel = shadow_q[cfg_idx].match_mask;
                F_XLAT_MASK:  rdata_sel = shadow_q[cfg_idx].xlat_mask;
                F_XLAT_BASE:  rdata_sel = shadow_q[cfg_idx].xlat_base;
                F_FLAGS:      rdata_sel = ADDR_W'(shadow_q[cfg_idx].flags);
`ifdef MAPPER_HITCNT_EN
                F_HITCNT:     rdata_sel = ADDR_W'(hitcnt_q[cfg_idx]);
`endif
                default:      rdata_sel = '0;
            endcase
        end
        rdata_d = cfg_re ? rdata_sel : rdata_q;
    end

    always_comb begin
        addr1_d = SNES_ADDR;
        for (int i = 0; i < NUM_WIN; i++) begin
            match1_d[i] = active_q[i].flags[FL_EN]
                && ((SNES_ADDR & active_q[i].match_mask) == (active_q[i].match_val & active_q[i].match_mask));
        end
    end

    // Scanning downward leaves the lowest matching index as the winner.
    always_comb begin
        win_hit = 1'b0;
        win_idx = '0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (match1_q[i]) begin
                win_hit = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
        rom_hit_d  = win_hit;
        hit_idx_d  = '0;
        rom_addr_d = '0;
        saveram_d  = 1'b0;
        writable_d = 1'b0;
        if (win_hit) begin
            hit_idx_d  = win_idx;
            rom_addr_d = active_q[win_idx].xlat_base + (addr1_q & active_q[win_idx].xlat_mask);
            saveram_d  = active_q[win_idx].flags[FL_SAV];
            writable_d = active_q[win_idx].flags[FL_WR];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the window tables are reset explicitly: every window must come out of reset disabled, which a reset-less RAM cannot guarantee.
            for (int i = 0; i < NUM_WIN; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            rdata_q    <= '0;
            addr1_q    <= '0;
            match1_q   <= '0;
            rom_addr_q <= '0;
            rom_hit_q  <= 1'b0;
            saveram_q  <= 1'b0;
            writable_q <= 1'b0;
            hit_idx_q  <= '0;
        end else begin
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            rdata_q    <= rdata_d;
            addr1_q    <= addr1_d;
            match1_q   <= match1_d;
            rom_addr_q <= rom_addr_d;
            rom_hit_q  <= rom_hit_d;
            saveram_q  <= saveram_d;
            writable_q <= writable_d;
            hit_idx_q  <= hit_idx_d;
        end
    end

    assign cfg_rdata      = rdata_q;
    assign cfg_pending    = (state_q == PEND);
    assign cfg_commit_ack = ack_q;
    assign ROM_ADDR       = rom_addr_q;
    assign ROM_HIT        = rom_hit_q;
    assign IS_SAVERAM     = saveram_q;
    assign IS_WRITABLE    = writable_q;
    assign hit_idx        = hit_idx_q;

endmodule
